// File: rtl/pr_pkg.sv
// Shared types for the Q-channel power/retention sequencer.
// Holds the sequencer state encoding and a small state helper.
package pr_pkg;

  localparam int PR_STATE_W = 4;

  typedef enum logic [3:0] {
    RUN,
    REQ,
    DENY,
    ISO,
    SAVE,
    OFF,
    PWR_ON,
    RESTORE,
    EXIT
  } pr_state_e;

  function automatic logic pr_is_busy(pr_state_e s);
    return s != RUN;
  endfunction

endpackage

// File: rtl/pr_idle_timer.sv
// Idle timer: hit rises after IDLE_CYC consecutive idle cycles.
// Ports: clk, resetn (async low), clr, idle in; hit out.
module pr_idle_timer #(
  parameter int IDLE_CYC = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic idle,
  output logic hit
);

  localparam int W = $clog2(IDLE_CYC + 1);
  localparam logic [W-1:0] LAST = W'(IDLE_CYC);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !idle) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == LAST);

endmodule

// File: rtl/pr_qch_pwr_seq.sv
// Q-channel power/retention sequencer (always-on domain).
// In: clk, resetn, sleep_req, wake_req, core_idle, qacceptn, qdeny,
//     pwr_ack. Out: qreqn, iso_en, ret_save, pwr_en, pr_restore,
//     busy, deny_cnt. PR_IDLE_TIMER_EN adds the idle auto-request.
module pr_qch_pwr_seq
  import pr_pkg::*;
#(
  parameter int PWR_DLY  = 4,
  parameter int IDLE_CYC = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sleep_req,
  input  logic             wake_req,
  input  logic             core_idle,
  input  logic             qacceptn,
  input  logic             qdeny,
  input  logic             pwr_ack,
  output logic             qreqn,
  output logic             iso_en,
  output logic             ret_save,
  output logic             pwr_en,
  output logic             pr_restore,
  output logic             busy,
  output logic [CNT_W-1:0] deny_cnt
);

  localparam int DW = (PWR_DLY > 1) ? $clog2(PWR_DLY) : 1;
  localparam logic [DW-1:0] DLY_LAST = DW'(PWR_DLY - 1);

  pr_state_e state_q, state_d;
  logic qreqn_q, qreqn_d;
  logic iso_q, iso_d;
  logic save_q, save_d;
  logic pwren_q, pwren_d;
  logic rest_q, rest_d;
  logic busy_q;
  logic armed_q, armed_d;
  logic wpend_q, wpend_d;
  logic [CNT_W-1:0] deny_q, deny_d;
  logic [DW-1:0] dly_q, dly_d;
  logic req;

`ifdef PR_IDLE_TIMER_EN
  logic idle_hit;

  pr_idle_timer #(
    .IDLE_CYC (IDLE_CYC)
  ) u_idle (
    .clk    (clk),
    .resetn (resetn),
    .clr    (state_q != RUN),
    .idle   (core_idle),
    .hit    (idle_hit)
  );

  assign req = sleep_req | idle_hit;
`else
  logic unused_idle;
  assign unused_idle = core_idle ^ IDLE_CYC[0];
  assign req = sleep_req;
`endif

  always_comb begin
    state_d = state_q;
    qreqn_d = qreqn_q;
    iso_d   = iso_q;
    save_d  = 1'b0;
    pwren_d = pwren_q;
    rest_d  = 1'b0;
    armed_d = armed_q;
    wpend_d = wpend_q;
    deny_d  = deny_q;
    dly_d   = dly_q;
    // A held sleep_req must drop once before it may re-arm.
    if (!sleep_req) armed_d = 1'b1;
    unique case (state_q)
      RUN: begin
        if (req && armed_q && qacceptn && !qdeny) begin
          qreqn_d = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!qacceptn) begin
          iso_d   = 1'b1;
          state_d = ISO;
        end else if (qdeny) begin
          qreqn_d = 1'b1;
          armed_d = 1'b0;
          deny_d  = (&deny_q) ? deny_q : deny_q + 1'b1;
          state_d = DENY;
        end
      end
      DENY: begin
        if (!qdeny && qacceptn) state_d = RUN;
      end
      ISO: begin
        save_d  = 1'b1;
        state_d = SAVE;
        if (wake_req) wpend_d = 1'b1;
      end
      SAVE: begin
        pwren_d = 1'b0;
        state_d = OFF;
        if (wake_req) wpend_d = 1'b1;
      end
      OFF: begin
        if (wake_req || wpend_q) begin
          pwren_d = 1'b1;
          wpend_d = 1'b0;
          dly_d   = '0;
          state_d = PWR_ON;
        end
      end
      PWR_ON: begin
        // Settle counts only consecutive pwr_ack cycles.
        if (!pwr_ack) begin
          dly_d = '0;
        end else if (dly_q == DLY_LAST) begin
          dly_d   = '0;
          rest_d  = 1'b1;
          state_d = RESTORE;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      RESTORE: begin
        qreqn_d = 1'b1;
        iso_d   = 1'b0;
        state_d = EXIT;
      end
      EXIT: begin
        if (qacceptn) state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
      qreqn_q <= 1'b1;
      iso_q   <= 1'b0;
      save_q  <= 1'b0;
      pwren_q <= 1'b1;
      rest_q  <= 1'b0;
      busy_q  <= 1'b0;
      armed_q <= 1'b1;
      wpend_q <= 1'b0;
      deny_q  <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      qreqn_q <= qreqn_d;
      iso_q   <= iso_d;
      save_q  <= save_d;
      pwren_q <= pwren_d;
      rest_q  <= rest_d;
      busy_q  <= pr_is_busy(state_d);
      armed_q <= armed_d;
      wpend_q <= wpend_d;
      deny_q  <= deny_d;
      dly_q   <= dly_d;
    end
  end

  assign qreqn      = qreqn_q;
  assign iso_en     = iso_q;
  assign ret_save   = save_q;
  assign pwr_en     = pwren_q;
  assign pr_restore = rest_q;
  assign busy       = busy_q;
  assign deny_cnt   = deny_q;

  a_exit_no_deny: assert property (
    @(posedge clk) disable iff (!resetn)
    state_q == EXIT |-> !qdeny
  ) else $error("qdeny asserted during EXIT");

  a_restore_exit: assert property (
    @(posedge clk) disable iff (!resetn)
    $rose(rest_q) |=> $rose(qreqn_q) && $fell(rest_q)
  ) else $error("pr_restore not followed by qreqn rise");

endmodule

// File: tb/tb_pr_qch_pwr_seq.sv
// Bench for pr_qch_pwr_seq: vector tables through a scoreboard.
// Define PR_IDLE_TIMER_EN to cover the idle-timer build.
module tb_pr_qch_pwr_seq;

  localparam int CNT_W = 8;

  // outputs: {qreqn, iso_en, ret_save, pwr_en, pr_restore, busy}
  localparam logic [5:0] O_RUN  = 6'b100100;
  localparam logic [5:0] O_REQ  = 6'b000101;
  localparam logic [5:0] O_DENY = 6'b100101;
  localparam logic [5:0] O_ISO  = 6'b010101;
  localparam logic [5:0] O_SAVE = 6'b011101;
  localparam logic [5:0] O_OFF  = 6'b010001;
  localparam logic [5:0] O_PWR  = 6'b010101;
  localparam logic [5:0] O_RST  = 6'b010111;
  localparam logic [5:0] O_EXIT = 6'b100101;

  logic clk = 1'b0;
  logic resetn;
  logic sleep_req, wake_req, core_idle;
  logic qacceptn, qdeny, pwr_ack;
  logic qreqn, iso_en, ret_save, pwr_en, pr_restore, busy;
  logic [CNT_W-1:0] deny_cnt;

  // inputs: {sleep, wake, qacceptn, qdeny, pwr_ack, core_idle}
  typedef struct {
    logic [5:0] in;
    logic [5:0] exp;
    string      tag;
  } vec_t;

  typedef struct {
    logic [5:0] exp;
    string      tag;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pr_qch_pwr_seq #(
    .PWR_DLY  (4),
    .IDLE_CYC (16),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sleep_req  (sleep_req),
    .wake_req   (wake_req),
    .core_idle  (core_idle),
    .qacceptn   (qacceptn),
    .qdeny      (qdeny),
    .pwr_ack    (pwr_ack),
    .qreqn      (qreqn),
    .iso_en     (iso_en),
    .ret_save   (ret_save),
    .pwr_en     (pwr_en),
    .pr_restore (pr_restore),
    .busy       (busy),
    .deny_cnt   (deny_cnt)
  );

  function automatic void add(int n, logic [5:0] in,
                              logic [5:0] exp, string tag);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.in  = in;
      v.exp = exp;
      v.tag = $sformatf("%s[%0d]", tag, tbl.size());
      tbl.push_back(v);
    end
  endfunction

  task automatic drive(logic [5:0] in);
    {sleep_req, wake_req, qacceptn, qdeny, pwr_ack, core_idle} = in;
  endtask

  task automatic push(logic [5:0] exp, string tag);
    sb_t e;
    e.exp = exp;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    sb_t e;
    logic [5:0] got;
    got = {qreqn, iso_en, ret_save, pwr_en, pr_restore, busy};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty got=%b", got);
    end else begin
      e = sb.pop_front();
      if (got !== e.exp) begin
        failures++;
        $display("FAIL %s got=%b expected=%b", e.tag, got, e.exp);
      end
    end
  endtask

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Entered and left on a negedge.
  task automatic run_tbl();
    foreach (tbl[i]) begin
      drive(tbl[i].in);
      push(tbl[i].exp, tbl[i].tag);
      @(posedge clk);
      #1;
      check_sb();
      @(negedge clk);
    end
    tbl.delete();
  endtask

  initial begin
    resetn = 1'b0;
    drive(6'b001000);
    repeat (2) @(negedge clk);
    push(O_RUN, "reset_outs");
    check_sb();
    chk("reset_deny_cnt", int'(deny_cnt), 0);
    resetn = 1'b1;
    @(negedge clk);

    // full cycle
    add(3,  6'b101000, O_REQ,  "full");
    add(1,  6'b100000, O_ISO,  "full");
    add(1,  6'b100000, O_SAVE, "full");
    add(1,  6'b100000, O_OFF,  "full");
    add(14, 6'b000000, O_OFF,  "full");
    add(1,  6'b010000, O_PWR,  "full");
    add(1,  6'b000000, O_PWR,  "full");
    add(3,  6'b000010, O_PWR,  "full");
    add(1,  6'b000010, O_RST,  "full");
    add(2,  6'b000010, O_EXIT, "full");
    add(1,  6'b001010, O_RUN,  "full");
    add(1,  6'b001000, O_RUN,  "full");
    run_tbl();
    chk("full_deny_cnt", int'(deny_cnt), 0);

    // deny with held sleep_req, then re-arm
    add(1, 6'b101000, O_REQ,  "deny");
    add(2, 6'b101100, O_DENY, "deny");
    add(4, 6'b101000, O_RUN,  "deny");
    add(1, 6'b001000, O_RUN,  "deny");
    add(1, 6'b101000, O_REQ,  "deny");
    add(1, 6'b101100, O_DENY, "deny");
    add(1, 6'b001000, O_RUN,  "deny");
    run_tbl();
    chk("deny_cnt", int'(deny_cnt), 2);

    // wake pulse during ISO
    add(1, 6'b101000, O_REQ,  "early");
    add(1, 6'b100000, O_ISO,  "early");
    add(1, 6'b110000, O_SAVE, "early");
    add(1, 6'b000000, O_OFF,  "early");
    add(1, 6'b000000, O_PWR,  "early");
    add(3, 6'b000010, O_PWR,  "early");
    add(1, 6'b000010, O_RST,  "early");
    add(1, 6'b000010, O_EXIT, "early");
    add(2, 6'b001000, O_RUN,  "early");
    run_tbl();

    // pwr_ack drop two cycles into settle
    add(1, 6'b101000, O_REQ,  "glitch");
    add(1, 6'b100000, O_ISO,  "glitch");
    add(1, 6'b000000, O_SAVE, "glitch");
    add(1, 6'b000000, O_OFF,  "glitch");
    add(1, 6'b010000, O_PWR,  "glitch");
    add(2, 6'b000010, O_PWR,  "glitch");
    add(1, 6'b000000, O_PWR,  "glitch");
    add(3, 6'b000010, O_PWR,  "glitch");
    add(1, 6'b000010, O_RST,  "glitch");
    add(1, 6'b000010, O_EXIT, "glitch");
    add(1, 6'b001010, O_RUN,  "glitch");
    run_tbl();

    // asynchronous reset while powered off
    add(1, 6'b101000, O_REQ,  "rstoff");
    add(1, 6'b100000, O_ISO,  "rstoff");
    add(1, 6'b000000, O_SAVE, "rstoff");
    add(2, 6'b000000, O_OFF,  "rstoff");
    run_tbl();
    #2 resetn = 1'b0;
    #1;
    push(O_RUN, "rstoff_async");
    check_sb();
    chk("rstoff_deny_cnt", int'(deny_cnt), 0);
    @(negedge clk);
    drive(6'b001000);
    resetn = 1'b1;
    @(negedge clk);

`ifdef PR_IDLE_TIMER_EN
    add(15, 6'b001001, O_RUN,  "idle");
    add(1,  6'b001000, O_RUN,  "idle");
    add(16, 6'b001001, O_RUN,  "idle");
    add(1,  6'b001001, O_REQ,  "idle");
    add(1,  6'b001101, O_DENY, "idle");
    add(1,  6'b001000, O_RUN,  "idle");
    run_tbl();
`else
    add(20, 6'b001001, O_RUN, "noidle");
    run_tbl();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
